// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller:
// FSM state encoding and the control bundle bit order.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_e;

  // MSB-first order matches the datapath control bus
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic memwb_write;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } ctl_t;

  localparam int CTL_W = $bits(ctl_t);

  function automatic ctl_t ctl_run();
    ctl_t c;
    c = '0;
    c.pc_write    = 1'b1;
    c.ifid_write  = 1'b1;
    c.idex_write  = 1'b1;
    c.exmem_write = 1'b1;
    c.memwb_write = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush
// performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: PC and pipeline
// register enables, halt on ebreak or memory timeout.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             exe_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wb_ebreak,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(MEM_TIMEOUT);

  state_e        state, state_nxt;
  logic [TW-1:0] wait_cnt, wait_nxt;
  logic          err_set;
  logic          mem_stall;
  logic          stall_inc;
  logic          flush_inc;
  ctl_t          ctl;

  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    ctl       = '0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (state != S_HALT) begin
      ctl = ctl_run();
      if (mem_stall) begin
        // freeze up to MEM; bubble flows into WB
        ctl.pc_write    = 1'b0;
        ctl.ifid_write  = 1'b0;
        ctl.idex_write  = 1'b0;
        ctl.exmem_write = 1'b0;
        ctl.memwb_flush = 1'b1;
        stall_inc       = 1'b1;
      end else if (exe_redirect) begin
        ctl.ifid_flush = 1'b1;
        ctl.idex_flush = 1'b1;
        flush_inc      = 1'b1;
      end else if (pause) begin
        ctl.pc_write   = 1'b0;
        ctl.ifid_write = 1'b0;
        ctl.idex_flush = 1'b1;
        stall_inc      = 1'b1;
      end
    end
    if (rst) begin
      ctl             = '0;
      ctl.ifid_flush  = 1'b1;
      ctl.idex_flush  = 1'b1;
      ctl.memwb_flush = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_set   = 1'b0;
    unique case (state)
      S_RUN: begin
        if (mem_stall) begin
          state_nxt = S_MEM_WAIT;
          wait_nxt  = TW'(1);
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = S_RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == TMO) begin
          state_nxt = S_HALT;
          err_set   = 1'b1;
        end else begin
          wait_nxt = wait_cnt + TW'(1);
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_RUN;
        wait_nxt  = '0;
      end
    endcase
    // ebreak retires this cycle and wins over a timeout
    if (wb_ebreak && state != S_HALT) begin
      state_nxt = S_HALT;
      err_set   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) mem_err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .q   (flush_cnt)
  );

  assign halted      = (state == S_HALT) && !rst;
  assign pc_write    = ctl.pc_write;
  assign ifid_write  = ctl.ifid_write;
  assign idex_write  = ctl.idex_write;
  assign exmem_write = ctl.exmem_write;
  assign memwb_write = ctl.memwb_write;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;
  assign memwb_flush = ctl.memwb_flush;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus
// random stimulus against a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, pause, exe_redirect;
  logic          mem_req, mem_ready, wb_ebreak;
  logic          pc_write, ifid_write, idex_write;
  logic          exmem_write, memwb_write;
  logic          ifid_flush, idex_flush, memwb_flush;
  logic          halted, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .MEM_TIMEOUT (TMO),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pause        (pause),
    .exe_redirect (exe_redirect),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .wb_ebreak    (wb_ebreak),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_write   (idex_write),
    .exmem_write  (exmem_write),
    .memwb_write  (memwb_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .memwb_flush  (memwb_flush),
    .halted       (halted),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: known after first reset edge
  bit m_known = 0;
  bit m_halt, m_wait, m_err;
  int m_wlen, m_stall, m_flush;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // bus order: pc ifid idex exmem memwb | ifid_f idex_f memwb_f
  task automatic step(input bit r, p, x, q, y, e);
    logic [7:0] got, exp, msk;
    bit stl, lu, fl;
    rst = r; pause = p; exe_redirect = x;
    mem_req = q; mem_ready = y; wb_ebreak = e;
    stl = q && !y;
    fl  = !stl && x;
    lu  = !stl && !x && p;
    @(negedge clk);
    msk = 8'hff;
    if (r)           exp = 8'b00000_111;
    else if (m_halt) exp = 8'b00000_000;
    else if (stl) begin
      exp = 8'b00001_001;
      msk = 8'b11110_111;
    end
    else if (fl)     exp = 8'b11111_110;
    else if (lu) begin
      exp = 8'b00111_010;
      msk = 8'b11011_111;
    end
    else             exp = 8'b11111_000;
    got = {pc_write, ifid_write, idex_write,
           exmem_write, memwb_write,
           ifid_flush, idex_flush, memwb_flush};
    check("ctl", 32'(got & msk), 32'(exp & msk));
    check("halted", 32'(halted), 32'(m_halt && !r));
    if (m_known) begin
      check("mem_err", 32'(mem_err), 32'(m_err));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    end
    @(posedge clk);
    if (r) begin
      m_known = 1; m_halt = 0; m_wait = 0;
      m_err = 0; m_wlen = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halt) begin
      if (stl || lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (fl) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (e) begin
        m_halt = 1;
      end else if (m_wait) begin
        // m_wlen = cycles spent waiting so far
        if (y) begin
          m_wait = 0; m_wlen = 0;
        end else if (m_wlen == TMO) begin
          m_halt = 1; m_err = 1;
        end else begin
          m_wlen++;
        end
      end else if (stl) begin
        m_wait = 1; m_wlen = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; pause = 0; exe_redirect = 0;
    mem_req = 0; mem_ready = 0; wb_ebreak = 0;
    #1;
    do_reset();
    check("rst_halted", 32'(halted), 0);
    check("rst_err", 32'(mem_err), 0);
    check("rst_stall", 32'(stall_cnt), 0);
    check("rst_flush", 32'(flush_cnt), 0);

    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("lu_stall", 32'(stall_cnt), 1);

    do_reset();
    step(0, 1, 1, 0, 0, 0);
    check("rp_flush", 32'(flush_cnt), 1);
    check("rp_stall", 32'(stall_cnt), 0);

    do_reset();
    repeat (3) step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    check("mw_stall", 32'(stall_cnt), 3);
    check("mw_flush", 32'(flush_cnt), 1);
    check("mw_halted", 32'(halted), 0);

    do_reset();
    repeat (5) step(0, 0, 0, 1, 0, 0);
    check("to_halted", 32'(halted), 1);
    check("to_err", 32'(mem_err), 1);
    repeat (3) step(0, 1, 1, 1, 1, 0);
    check("to_frozen", 32'(stall_cnt), 5);

    do_reset();
    step(0, 0, 0, 0, 0, 1);
    check("eb_halted", 32'(halted), 1);
    check("eb_err", 32'(mem_err), 0);
    repeat (2) step(0, 1, 0, 1, 0, 0);
    check("eb_frozen", 32'(stall_cnt), 0);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 79) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
